instr_ram_arbiter: RTL
======================

# instr_ram_arbiter

Two-port arbiter placed in front of the instruction RAM wrapper, which combines the single-port RAM and the boot ROM. It shares the single access port between the core instruction-fetch port and a loader port (debug/AXI preload) using fixed fetch priority plus a starvation guard. It forwards one request per cycle, routes the one-cycle-latency read data back to the owning port, and rejects loader writes into the boot-ROM region.

## Interface
Parameters:
- ADDR_WIDTH, 14, word address width toward the RAM wrapper; the MSB selects the boot region.
- STARVE_LIMIT, 4, number of consecutive denied loader cycles before the loader is forced to win; legal range 1..255.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- fetch_req_i  in  1  fetch read request.
- fetch_addr_i  in  ADDR_WIDTH  fetch word address.
- fetch_gnt_o  out  1  fetch request accepted this cycle.
- fetch_rvalid_o  out  1  fetch read data valid.
- fetch_rdata_o  out  32  fetch read data.
- ld_req_i  in  1  loader request.
- ld_addr_i  in  ADDR_WIDTH  loader word address.
- ld_we_i  in  1  loader write (1) or read (0).
- ld_be_i  in  4  loader byte enables.
- ld_wdata_i  in  32  loader write data.
- ld_gnt_o  out  1  loader request accepted.
- ld_rvalid_o  out  1  loader response valid (reads and writes).
- ld_rdata_o  out  32  loader read data.
- ld_err_o  out  1  asserted together with ld_rvalid_o when the write targeted the boot region.
- ram_en_o, ram_we_o  out  1 each  RAM wrapper enable and write enable.
- ram_addr_o  out  ADDR_WIDTH  RAM wrapper address.
- ram_be_o  out  4  RAM wrapper byte enables.
- ram_wdata_o  out  32  RAM wrapper write data.
- ram_rdata_i  in  32  RAM wrapper read data, valid one cycle after ram_en_o.

## Operation
- Grant is combinational. With no lock active, fetch wins if fetch_req_i is high, unless starve_cnt == STARVE_LIMIT and ld_req_i is high, in which case the loader wins. At most one grant per cycle.
- The starve_cnt register saturates at STARVE_LIMIT. It increments when ld_req_i && !ld_gnt_o, and clears when ld_gnt_o is high or ld_req_i is low.
- The winning port's addr, we, be and wdata are muxed to ram_*_o. Fetch accesses always use we=0 and be=4'hF. When there is no grant, ram_en_o=0 and ram_we_o=0.
- A loader write with ld_addr_i[ADDR_WIDTH-1]=1 is still granted, but it drives ram_en_o=0 and the boot region is not modified. Its response carries ld_err_o=1.
- Loader reads from the boot region are allowed and pass to the wrapper normally.
- Response owner register resp_q ∈ {NONE, FETCH, LD, LD_ERR} is loaded each cycle from the grant. It drives rvalid/err for the following cycle.
- fetch_rdata_o and ld_rdata_o both carry ram_rdata_i unconditionally and are meaningful only with their rvalid. For loader writes, ld_rdata_o is don't-care.

## Timing
- Request to grant: 0 cycles. Grant to rvalid: exactly 1 cycle. Back-to-back grants every cycle are supported, so throughput is 1 access per cycle.
- Requesters must hold req/addr/data stable until granted. Dropping req before grant is allowed and cancels the request.
- Simultaneous requests: fetch wins except when the starvation guard is saturated. After a forced loader grant, starve_cnt clears and fetch regains priority the next cycle.
- Reset values: all *_gnt_o=0, *_rvalid_o=0, ld_err_o=0, ram_en_o=0, ram_we_o=0, starve_cnt=0, resp_q=NONE.
- Reset asserted mid-access: the pending response is dropped and no rvalid is produced after reset release.

## Configuration
- Macro INSTR_ARB_LD_LOCK_EN.
- Defined: adds input ld_lock_i (1 bit). While ld_lock_i=1, fetch_gnt_o is forced to 0 and the loader gets every cycle it requests. starve_cnt is held at 0. This is used to preload the RAM while the core is halted.
- Undefined: the port is absent and arbitration is as described in Operation.

## Test plan
- Fetch only: fetch_req_i=1, addr 0x0010 for 3 cycles. Expect a grant each cycle, ram_addr_o=0x0010, ram_we_o=0, and fetch_rvalid_o high in cycles 2–4 with rdata = the RAM model word.
- Contention: both requesting continuously with STARVE_LIMIT=4. Expect fetch granted 4 cycles, then the loader granted in cycle 5, then fetch again in cycle 6. Repeat the pattern and check that ld_rvalid_o follows each loader grant by 1 cycle.
- Loader write: ld_we_i=1, addr 0x0020, be=4'b0011, wdata 0xDEADBEEF. Then read back 0x0020 and expect 0x0000BEEF over the prior 0x00000000 contents.
- Boot write reject: loader write to addr 0x2004. Expect ld_gnt_o=1 and ram_en_o=0, then next cycle ld_rvalid_o=1 and ld_err_o=1, with ROM contents unchanged. A loader read of 0x2004 returns the ROM word with ld_err_o=0.
- Reset mid-access: grant a fetch, assert rst_n=0 in the same cycle. Expect fetch_rvalid_o=0 and starve_cnt=0 after release.
- With INSTR_ARB_LD_LOCK_EN and ld_lock_i=1: fetch_req_i=1 and ld_req_i=1 for 10 cycles. Expect 10 loader grants and 0 fetch grants.

Source files
------------

// File: rtl/instr_ram_arbiter.sv
// rtl/instr_ram_arbiter.sv - fetch/loader arbiter in front of the instruction RAM wrapper
//
// Shares the single RAM wrapper port between the core fetch port (read-only,
// fixed priority) and a loader port (read/write). A starvation counter forces
// a loader grant after STARVE_LIMIT consecutive denied loader cycles. Loader
// writes into the boot region (address MSB set) are granted but never reach
// the wrapper and are answered with ld_err_o.
//
// Optional macro INSTR_ARB_LD_LOCK_EN adds ld_lock_i: while high the loader
// owns the port outright and fetch is never granted.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   fetch_req_i/addr_i           fetch read request
//   fetch_gnt_o                  fetch accepted this cycle (combinational)
//   fetch_rvalid_o/rdata_o       fetch read response, one cycle after grant
//   ld_req_i/addr_i/we_i/be_i/wdata_i  loader request
//   ld_lock_i                    (INSTR_ARB_LD_LOCK_EN only) loader exclusive mode
//   ld_gnt_o                     loader accepted this cycle (combinational)
//   ld_rvalid_o/rdata_o/err_o    loader response, one cycle after grant
//   ram_en_o/we_o/addr_o/be_o/wdata_o  RAM wrapper access port
//   ram_rdata_i                  RAM wrapper read data, one cycle after ram_en_o

module instr_ram_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_req_i,
  input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
  output logic                  fetch_gnt_o,
  output logic                  fetch_rvalid_o,
  output logic [31:0]           fetch_rdata_o,
`ifdef INSTR_ARB_LD_LOCK_EN
  input  logic                  ld_lock_i,
`endif
  input  logic                  ld_req_i,
  input  logic [ADDR_WIDTH-1:0] ld_addr_i,
  input  logic                  ld_we_i,
  input  logic [3:0]            ld_be_i,
  input  logic [31:0]           ld_wdata_i,
  output logic                  ld_gnt_o,
  output logic                  ld_rvalid_o,
  output logic [31:0]           ld_rdata_o,
  output logic                  ld_err_o,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_FETCH,
    RESP_LD,
    RESP_LD_ERR
  } resp_e;

  localparam logic [7:0] STARVE_MAX = STARVE_LIMIT[7:0];

  resp_e      resp_q, resp_d;
  logic [7:0] starve_cnt, starve_d;
  logic       lock;
  logic       starve_sat;
  logic       ld_boot_wr;

`ifdef INSTR_ARB_LD_LOCK_EN
  assign lock = ld_lock_i;
`else
  assign lock = 1'b0;
`endif

  assign starve_sat = (starve_cnt == STARVE_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q     <= RESP_NONE;
      starve_cnt <= '0;
    end else begin
      resp_q     <= resp_d;
      starve_cnt <= starve_d;
    end
  end

  always_comb begin
    fetch_gnt_o = 1'b0;
    ld_gnt_o    = 1'b0;
    resp_d      = RESP_NONE;
    starve_d    = '0;

    // Loader wins when locked, when fetch is idle, or when it has waited long enough.
    if (ld_req_i && (lock || !fetch_req_i || starve_sat)) begin
      ld_gnt_o = 1'b1;
    end else if (fetch_req_i && !lock) begin
      fetch_gnt_o = 1'b1;
    end

    // Boot region is ROM: the write is acknowledged but kept off the wrapper.
    ld_boot_wr = ld_gnt_o && ld_we_i && ld_addr_i[ADDR_WIDTH-1];

    if (fetch_gnt_o) begin
      resp_d = RESP_FETCH;
    end else if (ld_boot_wr) begin
      resp_d = RESP_LD_ERR;
    end else if (ld_gnt_o) begin
      resp_d = RESP_LD;
    end

    // Counter tracks an unbroken run of denied loader cycles and saturates.
    if (!lock && ld_req_i && !ld_gnt_o) begin
      starve_d = starve_sat ? starve_cnt : starve_cnt + 8'd1;
    end
  end

  assign ram_en_o    = fetch_gnt_o || (ld_gnt_o && !ld_boot_wr);
  assign ram_we_o    = ld_gnt_o && ld_we_i && !ld_boot_wr;
  assign ram_addr_o  = ld_gnt_o ? ld_addr_i : fetch_addr_i;
  assign ram_be_o    = ld_gnt_o ? ld_be_i : 4'hF;
  assign ram_wdata_o = ld_wdata_i;

  assign fetch_rvalid_o = (resp_q == RESP_FETCH);
  assign ld_rvalid_o    = (resp_q == RESP_LD) || (resp_q == RESP_LD_ERR);
  assign ld_err_o       = (resp_q == RESP_LD_ERR);
  assign fetch_rdata_o  = ram_rdata_i;
  assign ld_rdata_o     = ram_rdata_i;

endmodule
